// File: rtl/stream_pacer.sv
// Valid/ready input buffered in a DEPTH-entry FIFO, drained as single-cycle
// enable_o strobes spaced by at least gap_i idle cycles.
module stream_pacer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [WIDTH-1:0]         s_data_i,
  input  logic [GAP_W-1:0]         gap_i,
  output logic                     enable_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, GAP} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [GAP_W-1:0]  cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              push, pop;

  // Ready comes only from the registered count, so a same-cycle pop never frees a full slot.
  assign s_ready_o = (count_q != FULL);
  assign push      = s_valid_i && s_ready_o && !flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    data_d  = data_q;
    pop     = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            pop    = 1'b1;
            en_d   = 1'b1;
            data_d = mem_q[rd_ptr_q];
            cnt_d  = gap_i;
            if (gap_i != '0) state_d = GAP;
          end
        end
        GAP: begin
          cnt_d = cnt_q - GAP_W'(1);
          if (cnt_q == GAP_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= s_data_i;
  end

  assign enable_o = en_q;
  assign data_o   = data_q;
  assign level_o  = count_q;

endmodule

// File: tb/tb_stream_pacer.sv
// Randomized bench for stream_pacer against a queue/timestamp reference model.
module tb_stream_pacer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, s_valid, s_ready, enable;
  logic [WIDTH-1:0] s_data, data;
  logic [GAP_W-1:0] gap;
  logic [2:0]       level;

  always #5 clk = ~clk;

  stream_pacer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .s_valid_i(s_valid),
    .s_ready_o(s_ready), .s_data_i(s_data), .gap_i(gap),
    .enable_o(enable), .data_o(data), .level_o(level)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference: word queue plus the earliest cycle at which the next strobe is allowed.
  logic [WIDTH-1:0] mq[$];
  logic             m_en   = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  longint           cyc = 0, next_ok = 0;

  function automatic logic [3+WIDTH+1:0] expv();
    return {m_en, m_data, 3'(mq.size()), mq.size() != DEPTH};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_en = 1'b0; m_data = '0; next_ok = 0;
    end else if (flush) begin
      mq.delete(); m_en = 1'b0; next_ok = 0;
    end else begin
      bit rdy;
      rdy = (mq.size() != DEPTH);
      if (mq.size() > 0 && cyc >= next_ok) begin
        m_data  = mq.pop_front();
        m_en    = 1'b1;
        next_ok = cyc + longint'(gap) + 1;
      end else begin
        m_en = 1'b0;
      end
      if (s_valid && rdy) mq.push_back(s_data);
    end
    cyc++;
    #1;
  endtask

  task automatic settle();
    s_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; s_valid = 1'b1; s_data = 8'hEE; gap = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin rst = 1'b0; s_valid = 1'b0; end
      step();
      vectors++;
      if ({enable, data, level, s_ready} !== expv()) begin
        errors++;
        $display("FAIL reset[%0d] got en=%b d=%h lvl=%0d rdy=%b exp %b_%h_%0d_%b", i,
                 enable, data, level, s_ready, m_en, m_data, mq.size(), mq.size() != DEPTH);
      end
    end
    vectors++;
    if ({enable, data, level, s_ready} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_const got en=%b d=%h lvl=%0d rdy=%b exp 0 00 0 1", enable, data, level, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] words [3];
    logic             exp_en [5];
    logic [WIDTH-1:0] exp_d  [5];
    words  = '{8'h11, 8'h22, 8'h33};
    exp_en = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h33};
    gap = '0;
    for (int i = 0; i < 5; i++) begin
      s_valid = (i < 3);
      s_data  = (i < 3) ? words[i] : 8'h00;
      step();
      vectors++;
      if ({enable, data, level, s_ready} !== expv()) begin
        errors++;
        $display("FAIL b2b_model[%0d] got %b_%h_%0d_%b exp %b_%h_%0d", i,
                 enable, data, level, s_ready, m_en, m_data, mq.size());
      end
      vectors++;
      if ({enable, data} !== {exp_en[i], exp_d[i]}) begin
        errors++;
        $display("FAIL b2b_seq[%0d] got en=%b d=%h exp en=%b d=%h", i, enable, data, exp_en[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_pacing();
    longint st[$];
    logic [WIDTH-1:0] sd[$];
    settle();
    gap = 4'd3;
    for (int i = 0; i < 20; i++) begin
      s_valid = (i < 4);
      s_data  = 8'hA0 + 8'(i);
      step();
      vectors++;
      if ({enable, data, level, s_ready} !== expv()) begin
        errors++;
        $display("FAIL pace_model[%0d] got %b_%h_%0d_%b exp %b_%h_%0d", i,
                 enable, data, level, s_ready, m_en, m_data, mq.size());
      end
      if (enable) begin st.push_back(cyc); sd.push_back(data); end
    end
    vectors++;
    if (st.size() != 4) begin
      errors++;
      $display("FAIL pace_count got %0d strobes exp 4", st.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (sd[i] !== 8'hA0 + 8'(i) || (i > 0 && st[i] - st[i-1] != 4)) begin
          errors++;
          $display("FAIL pace_strobe[%0d] got d=%h spacing=%0d exp d=%h spacing=4", i, sd[i],
                   (i > 0) ? st[i] - st[i-1] : 4, 8'hA0 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int               sent = 0;
    bit               acc, saw_full = 0;
    logic [WIDTH-1:0] got[$];
    settle();
    gap = 4'd15;
    for (int c = 0; c < 200 && got.size() < 6; c++) begin
      s_valid = (sent < 6);
      s_data  = 8'h60 + 8'(sent);
      acc     = s_valid && (mq.size() != DEPTH);
      step();
      if (acc) sent++;
      if (level == 3'd4 && !s_ready) saw_full = 1;
      if (enable) got.push_back(data);
      vectors++;
      if ({enable, data, level, s_ready} !== expv()) begin
        errors++;
        $display("FAIL bp_model[%0d] got %b_%h_%0d_%b exp %b_%h_%0d", c,
                 enable, data, level, s_ready, m_en, m_data, mq.size());
      end
    end
    s_valid = 1'b0;
    vectors++;
    if (!saw_full) begin
      errors++;
      $display("FAIL bp_full got no full/not-ready cycle exp level=4 with ready=0");
    end
    vectors++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL bp_count got %0d words exp 6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (got[i] !== 8'h60 + 8'(i)) begin
          errors++;
          $display("FAIL bp_order[%0d] got %h exp %h", i, got[i], 8'h60 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_flush_mid_gap();
    settle();
    gap = 4'd7;
    for (int i = 0; i < 6; i++) begin
      s_valid = (i < 3) || (i == 3) || (i == 4);
      flush   = (i == 3);
      s_data  = (i < 3) ? 8'hC0 + 8'(i) : (i == 3) ? 8'hEE : 8'h5A;
      step();
      vectors++;
      if ({enable, data, level, s_ready} !== expv()) begin
        errors++;
        $display("FAIL flush_model[%0d] got %b_%h_%0d_%b exp %b_%h_%0d", i,
                 enable, data, level, s_ready, m_en, m_data, mq.size());
      end
      if (i == 3) begin
        vectors++;
        if ({level, s_ready, enable} !== {3'd0, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL flush_clear got lvl=%0d rdy=%b en=%b exp 0 1 0", level, s_ready, enable);
        end
      end
      if (i == 5) begin
        vectors++;
        if ({enable, data} !== {1'b1, 8'h5A}) begin
          errors++;
          $display("FAIL flush_after got en=%b d=%h exp en=1 d=5a", enable, data);
        end
      end
    end
    flush = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_reset_mid_gap();
    settle();
    gap = 4'd9;
    for (int i = 0; i < 6; i++) begin
      rst     = (i == 2);
      s_valid = (i == 0) || (i == 3);
      s_data  = (i == 0) ? 8'h71 : 8'h72;
      step();
      vectors++;
      if ({enable, data, level, s_ready} !== expv()) begin
        errors++;
        $display("FAIL rstgap_model[%0d] got %b_%h_%0d_%b exp %b_%h_%0d", i,
                 enable, data, level, s_ready, m_en, m_data, mq.size());
      end
    end
    vectors++;
    if (data !== 8'h72) begin
      errors++;
      $display("FAIL rstgap_after got d=%h exp 72", data);
    end
    rst = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_wrap_random();
    int               pushed = 0;
    int               c;
    bit               acc;
    logic [WIDTH-1:0] inq[$];
    logic [WIDTH-1:0] w;
    settle();
    for (c = 0; c < 20000 && (pushed < 1000 || mq.size() > 0); c++) begin
      s_valid = (pushed < 1000) && ($urandom_range(0, 1) == 1);
      s_data  = WIDTH'($urandom);
      gap     = GAP_W'($urandom_range(0, 4));
      acc     = s_valid && (mq.size() != DEPTH);
      if (acc) begin inq.push_back(s_data); pushed++; end
      step();
      vectors++;
      if ({enable, data, level, s_ready} !== expv()) begin
        errors++;
        $display("FAIL rand_model[%0d] got %b_%h_%0d_%b exp %b_%h_%0d", c,
                 enable, data, level, s_ready, m_en, m_data, mq.size());
      end
      if (enable && inq.size() > 0) begin
        w = inq.pop_front();
        vectors++;
        if (data !== w) begin
          errors++;
          $display("FAIL rand_order[%0d] got %h exp %h", c, data, w);
        end
      end
    end
    s_valid = 1'b0;
    step();
    vectors++;
    if (pushed != 1000 || inq.size() != 0) begin
      errors++;
      $display("FAIL rand_done got pushed=%0d left=%0d after %0d cycles exp 1000 0", pushed, inq.size(), c);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_pacing();
    test_backpressure();
    test_flush_mid_gap();
    test_reset_mid_gap();
    test_wrap_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
